// File: rtl/instr_pkg.sv
// Shared definitions for the instruction pairing front end: prefix opcode,
// queue entry layout and small decode helpers.
package instr_pkg;

  localparam logic [5:0] PRIMARY_OPCODE_PREFIX = 6'b100000;

  // Queue entries carry a full 64-bit address; narrower address ports zero-extend.
  localparam int ENTRY_AW = 64;

  typedef struct packed {
    logic [63:0]         instr;
    logic [ENTRY_AW-1:0] addr;
    logic                prefixed;
    logic                align_err;
  } instr_entry_t;

  function automatic logic is_prefix(input logic [31:0] word);
    return (word[5:0] == PRIMARY_OPCODE_PREFIX);
  endfunction

  // A prefix in the last word slot of a 64-byte block cannot take its suffix.
  function automatic logic at_block_end(input logic [3:0] word_idx);
    return (word_idx == 4'hF);
  endfunction

endpackage

// File: rtl/instr_pair_buffer_sync_fifo.sv
// Synchronous FIFO with flush; head data reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != CW'(0));
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign valid   = (count != CW'(0));
  assign dout    = valid ? mem[rd_ptr] : WIDTH'(0);

  // Storage array: written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= PW'(0);
      rd_ptr <= PW'(0);
      count  <= CW'(0);
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_pair_buffer.sv
// Pairs prefix words with their suffix and queues complete instructions
// (plain, prefixed, or boundary-faulted prefix) for the identification stage.
module instr_pair_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 64
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_flush,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [31:0]   i_word,
  input  logic [AW-1:0] i_addr,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [63:0]   o_instr,
  output logic [AW-1:0] o_addr,
  output logic          o_prefixed,
  output logic          o_align_err
);

  import instr_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic EXPECT_FIRST = 1'b0;
  localparam logic HAVE_PREFIX  = 1'b1;

  logic          state;
  logic          state_next;
  logic [31:0]   held_word;
  logic [AW-1:0] held_addr;
  logic          accept;
  logic          push;
  instr_entry_t  push_entry;
  instr_entry_t  head_entry;
  logic [CW-1:0] count;

  // Acceptance is based on the pre-pop count, so a full queue never accepts.
  assign o_ready = i_en && !i_rst && !i_flush && (count < CW'(DEPTH));
  assign accept  = i_valid && o_ready;

  // Entry formation and pairing state transition.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    push_entry = '0;
    if (accept) begin
      case (state)
        EXPECT_FIRST: begin
          if (!is_prefix(i_word)) begin
            push                = 1'b1;
            push_entry.instr    = {32'h0, i_word};
            push_entry.addr     = ENTRY_AW'(i_addr);
          end else if (at_block_end(i_addr[5:2])) begin
            push                 = 1'b1;
            push_entry.instr     = {32'h0, i_word};
            push_entry.addr      = ENTRY_AW'(i_addr);
            push_entry.prefixed  = 1'b1;
            push_entry.align_err = 1'b1;
          end else begin
            state_next = HAVE_PREFIX;
          end
        end
        HAVE_PREFIX: begin
          // Whatever arrives next is the suffix; its opcode is not examined.
          push                = 1'b1;
          push_entry.instr    = {i_word, held_word};
          push_entry.addr     = ENTRY_AW'(held_addr);
          push_entry.prefixed = 1'b1;
          state_next          = EXPECT_FIRST;
        end
        default: begin
          state_next = EXPECT_FIRST;
        end
      endcase
    end else begin
      state_next = state;
    end
  end

  // Pairing state and held prefix; reset and flush drop any half-formed pair.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      state     <= EXPECT_FIRST;
      held_word <= 32'h0;
      held_addr <= AW'(0);
    end else begin
      state <= state_next;
      if (accept && (state == EXPECT_FIRST)) begin
        held_word <= i_word;
        held_addr <= i_addr;
      end
    end
  end

  sync_fifo #(
    .WIDTH ($bits(instr_entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (i_clk),
    .rst   (i_rst),
    .flush (i_flush),
    .push  (push),
    .din   (push_entry),
    .pop   (i_ready),
    .dout  (head_entry),
    .valid (o_valid),
    .count (count)
  );

  assign o_instr     = head_entry.instr;
  assign o_addr      = head_entry.addr[AW-1:0];
  assign o_prefixed  = head_entry.prefixed;
  assign o_align_err = head_entry.align_err;

endmodule

// File: tb/tb_instr_pair_buffer.sv
// Directed self-checking bench for instr_pair_buffer.
module tb_instr_pair_buffer;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_en;
  logic        i_flush;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_word;
  logic [63:0] i_addr;
  logic        o_valid;
  logic        i_ready;
  logic [63:0] o_instr;
  logic [63:0] o_addr;
  logic        o_prefixed;
  logic        o_align_err;

  int checks = 0;
  int errors = 0;

  instr_pair_buffer #(.DEPTH(4), .AW(64)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .i_flush     (i_flush),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_word      (i_word),
    .i_addr      (i_addr),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_instr     (o_instr),
    .o_addr      (o_addr),
    .o_prefixed  (o_prefixed),
    .o_align_err (o_align_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [63:0] a);
    i_valid = v;
    i_word  = w;
    i_addr  = a;
  endtask

  task automatic chk_head(input string tag, input logic [63:0] instr, input logic [63:0] addr,
                          input logic pre, input logic aerr);
    chk({tag, ".valid"}, {63'h0, o_valid}, 64'h1);
    chk({tag, ".instr"}, o_instr, instr);
    chk({tag, ".addr"}, o_addr, addr);
    chk({tag, ".prefixed"}, {63'h0, o_prefixed}, {63'h0, pre});
    chk({tag, ".align_err"}, {63'h0, o_align_err}, {63'h0, aerr});
  endtask

  initial begin
    i_rst = 1'b1; i_en = 1'b1; i_flush = 1'b0; i_ready = 1'b1;
    drive(1'b0, 32'h0, 64'h0);
    tick();
    tick();
    // reset state
    chk("rst.valid", {63'h0, o_valid}, 64'h0);
    chk("rst.instr", o_instr, 64'h0);
    chk("rst.addr", o_addr, 64'h0);
    chk("rst.prefixed", {63'h0, o_prefixed}, 64'h0);
    chk("rst.align_err", {63'h0, o_align_err}, 64'h0);
    chk("rst.ready", {63'h0, o_ready}, 64'h0);
    i_rst = 1'b0;
    #1;
    chk("post_rst.ready", {63'h0, o_ready}, 64'h1);

    // plain stream
    drive(1'b1, 32'h7C0802A6, 64'h1000);
    tick();
    drive(1'b1, 32'h38600001, 64'h1004);
    chk_head("plain0", 64'h0000_0000_7C08_02A6, 64'h1000, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 64'h0);
    chk_head("plain1", 64'h0000_0000_3860_0001, 64'h1004, 1'b0, 1'b0);
    tick();
    chk("plain.empty", {63'h0, o_valid}, 64'h0);

    // prefix pair
    drive(1'b1, 32'h04000020, 64'h2008);
    tick();
    drive(1'b1, 32'h12345678, 64'h200C);
    chk("pair.no_early", {63'h0, o_valid}, 64'h0);
    tick();
    drive(1'b0, 32'h0, 64'h0);
    chk_head("pair", 64'h12345678_04000020, 64'h2008, 1'b1, 1'b0);
    tick();
    chk("pair.empty", {63'h0, o_valid}, 64'h0);

    // prefix in last word of a 64-byte block
    drive(1'b1, 32'h04000020, 64'h203C);
    tick();
    drive(1'b1, 32'h38600001, 64'h2040);
    chk_head("bound", 64'h0000_0000_0400_0020, 64'h203C, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 64'h0);
    chk_head("bound.next", 64'h0000_0000_3860_0001, 64'h2040, 1'b0, 1'b0);
    tick();

    // backpressure: only DEPTH words accepted
    i_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 32'h1000_0000 + k, 64'h3000 + 64'(4 * k));
      #1;
      chk($sformatf("bp.ready%0d", k), {63'h0, o_ready}, (k < 4) ? 64'h1 : 64'h0);
      tick();
    end
    drive(1'b0, 32'h0, 64'h0);
    i_ready = 1'b1;
    #1;
    chk("bp.full_pop_ready", {63'h0, o_ready}, 64'h0);
    for (int k = 0; k < 4; k++) begin
      chk_head($sformatf("bp.drain%0d", k), 64'h1000_0000 + 64'(k), 64'h3000 + 64'(4 * k), 1'b0, 1'b0);
      tick();
    end
    chk("bp.empty", {63'h0, o_valid}, 64'h0);

    // flush mid-pair
    drive(1'b1, 32'h04000020, 64'h4000);
    tick();
    drive(1'b1, 32'h12345678, 64'h4004);
    i_flush = 1'b1;
    #1;
    chk("flush.ready", {63'h0, o_ready}, 64'h0);
    tick();
    i_flush = 1'b0;
    drive(1'b0, 32'h0, 64'h0);
    chk("flush.valid0", {63'h0, o_valid}, 64'h0);
    tick();
    chk("flush.valid1", {63'h0, o_valid}, 64'h0);
    drive(1'b1, 32'h38600001, 64'h4008);
    tick();
    drive(1'b0, 32'h0, 64'h0);
    chk_head("flush.next", 64'h0000_0000_3860_0001, 64'h4008, 1'b0, 1'b0);
    tick();

    // reset with three queued entries and a held prefix
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h2000_0001 + k, 64'h5000 + 64'(4 * k));
      tick();
    end
    drive(1'b1, 32'h04000020, 64'h5010);
    tick();
    drive(1'b0, 32'h0, 64'h0);
    chk_head("mid.head", 64'h2000_0001, 64'h5000, 1'b0, 1'b0);
    i_rst = 1'b1;
    tick();
    chk("mid_rst.valid", {63'h0, o_valid}, 64'h0);
    chk("mid_rst.instr", o_instr, 64'h0);
    chk("mid_rst.addr", o_addr, 64'h0);
    chk("mid_rst.prefixed", {63'h0, o_prefixed}, 64'h0);
    chk("mid_rst.ready", {63'h0, o_ready}, 64'h0);
    i_rst = 1'b0;
    i_ready = 1'b1;
    drive(1'b1, 32'h12345678, 64'h5014);
    tick();
    drive(1'b0, 32'h0, 64'h0);
    chk_head("mid_rst.next", 64'h0000_0000_1234_5678, 64'h5014, 1'b0, 1'b0);
    tick();
    chk("mid_rst.empty", {63'h0, o_valid}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
